fifo_frame_ptr_ctrl: RTL and testbench

Parametrised successor of the FIFO pointer/flag block, for the matrix-FIFO datapath. Owns read/write pointers for a power-of-two FIFO of DEPTH entries and drives RAM addresses and gated enables. Produces full/empty, almost-full/almost-empty and occupancy level. A frame FSM asserts ready once n*n words of a frame have been written, then tracks the frame's drain.

---
 rtl/fifo_frame_ptr_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fifo_frame_ptr_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_ptr_ctrl.sv
// Read/write pointer, flag and frame-tracking control for a power-of-two FIFO.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_frame_ptr_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int N_W    = 4,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [N_W-1:0]    n,
    input  logic              clr_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              ready,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  AF_L    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0]  AE_L    = (ADDR_W+1)'(AE_LVL);
    localparam logic [2*N_W:0]   FC_ONE  = (2*N_W+1)'(1);
    localparam logic [2*N_W-1:0] LEN_ONE = (2*N_W)'(1);

    typedef enum logic [1:0] {IDLE, FILL, RDY, DRAIN} state_t;

    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    state_t           state;
    state_t           state_nx;
    logic [2*N_W:0]   fcnt;
    logic [2*N_W:0]   fcnt_nx;
    logic [2*N_W:0]   fcnt_inc;
    logic [2*N_W:0]   len_ext;
    logic [2*N_W-1:0] frame_len;
    logic [2*N_W-1:0] frame_len_nx;
    logic [2*N_W-1:0] n_sq;

    // The extra pointer MSB distinguishes a full FIFO from an empty one.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);
    assign wr_addr      = wr_ptr[ADDR_W-1:0];
    assign rd_addr      = rd_ptr[ADDR_W-1:0];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign n_sq     = {{N_W{1'b0}}, n} * {{N_W{1'b0}}, n};
    assign fcnt_inc = fcnt + FC_ONE;
    assign len_ext  = {1'b0, frame_len};

    always_comb begin
        state_nx     = state;
        fcnt_nx      = fcnt;
        frame_len_nx = frame_len;
        case (state)
            IDLE: begin
                if (wr_en && (n != '0)) begin
                    frame_len_nx = n_sq;
                    if (n_sq == LEN_ONE) begin
                        state_nx = RDY;
                        fcnt_nx  = '0;
                    end else begin
                        state_nx = FILL;
                        fcnt_nx  = FC_ONE;
                    end
                end
            end
            FILL: begin
                if (wr_en) begin
                    if (fcnt_inc == len_ext) begin
                        state_nx = RDY;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx = fcnt_inc;
                    end
                end
            end
            RDY: begin
                if (rd_en) begin
                    if (frame_len == LEN_ONE) begin
                        state_nx = IDLE;
                        fcnt_nx  = '0;
                    end else begin
                        state_nx = DRAIN;
                        fcnt_nx  = FC_ONE;
                    end
                end
            end
            DRAIN: begin
                if (rd_en) begin
                    if (fcnt_inc == len_ext) begin
                        state_nx = IDLE;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx = fcnt_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                fcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fcnt      <= '0;
            frame_len <= '0;
            ready     <= 1'b0;
        end else begin
            state     <= state_nx;
            fcnt      <= fcnt_nx;
            frame_len <= frame_len_nx;
            ready     <= (state_nx == RDY);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // clr_err wins over a set arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !wr_en) overflow  <= 1'b1;
            if (pop && !rd_en)  underflow <= 1'b1;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_frame_ptr_ctrl.sv
// Self-checking bench for fifo_frame_ptr_ctrl: hand-written vector table plus an
// occupancy/frame model whose predictions are queued and compared after each clock.
module tb_fifo_frame_ptr_ctrl;

    localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_RDY   = 2;
    localparam int S_DRAIN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] n = '0;
    logic       wr_en, rd_en, empty, full, almost_empty, almost_full, ready, overflow, underflow;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] level;

    fifo_frame_ptr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .n(n), .clr_err(clr_err),
        .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .level(level), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .ready(ready), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd;
        logic [4:0] level;
        logic [3:0] wa, ra;
        logic       empty, full, ae, af, ready, ovf, unf;
    } exp_t;

    typedef struct {
        bit         r, p, q, c;
        logic [3:0] nn;
        logic       exp_wr, exp_rd;
        logic [4:0] exp_level;
        logic       exp_ready;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   m_cnt, m_wa, m_ra, m_state, m_fc, m_len;
    bit   m_ready, m_ovf, m_unf;
    logic cap_wr, cap_rd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt = 0; m_wa = 0; m_ra = 0; m_state = S_IDLE; m_fc = 0; m_len = 0;
        m_ready = 0; m_ovf = 0; m_unf = 0;
    endtask

    // One clock: drive, predict, clock, then pop the prediction and compare.
    task automatic applyStimulus(input bit r, input bit p, input bit q, input logic [3:0] nn, input bit c);
        exp_t e;
        exp_t g;
        bit   mw, mr;
        @(negedge clk);
        rst = r; push = p; pop = q; n = nn; clr_err = c;
        #1;
        cap_wr = wr_en;
        cap_rd = rd_en;
        mw = p && ((m_cnt < DEPTH) || q);
        mr = q && (m_cnt > 0);
        e.wr = mw;
        e.rd = mr;
        if (r) begin
            modelReset();
        end else begin
            m_cnt = m_cnt + int'(mw) - int'(mr);
            m_wa = (m_wa + int'(mw)) % DEPTH;
            m_ra = (m_ra + int'(mr)) % DEPTH;
            case (m_state)
                S_IDLE: if (mw && nn != 0) begin
                    m_len = int'(nn) * int'(nn);
                    if (m_len == 1) begin m_state = S_RDY; m_fc = 0; end
                    else begin m_state = S_FILL; m_fc = 1; end
                end
                S_FILL: if (mw) begin
                    m_fc++;
                    if (m_fc == m_len) begin m_state = S_RDY; m_fc = 0; end
                end
                S_RDY: if (mr) begin
                    if (m_len == 1) m_state = S_IDLE;
                    else begin m_state = S_DRAIN; m_fc = 1; end
                end
                default: if (mr) begin
                    m_fc++;
                    if (m_fc == m_len) begin m_state = S_IDLE; m_fc = 0; end
                end
            endcase
            m_ready = (m_state == S_RDY);
            if (ERR_EN) begin
                if (c) begin m_ovf = 0; m_unf = 0; end
                else begin
                    if (p && !mw) m_ovf = 1;
                    if (q && !mr) m_unf = 1;
                end
            end
        end
        e.level = 5'(m_cnt);
        e.wa    = 4'(m_wa);
        e.ra    = 4'(m_ra);
        e.empty = (m_cnt == 0);
        e.full  = (m_cnt == DEPTH);
        e.ae    = (m_cnt <= 2);
        e.af    = (m_cnt >= DEPTH - 2);
        e.ready = m_ready;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checkOutput("wr_en", cap_wr, g.wr);
        checkOutput("rd_en", cap_rd, g.rd);
        checkOutput("level", level, g.level);
        checkOutput("wr_addr", wr_addr, g.wa);
        checkOutput("rd_addr", rd_addr, g.ra);
        checkOutput("empty", empty, g.empty);
        checkOutput("full", full, g.full);
        checkOutput("almost_empty", almost_empty, g.ae);
        checkOutput("almost_full", almost_full, g.af);
        checkOutput("ready", ready, g.ready);
        checkOutput("overflow", overflow, g.ovf);
        checkOutput("underflow", underflow, g.unf);
    endtask

    vec_t vecs[12];

    initial begin
        logic [4:0] lvl_before;
        logic [3:0] wa_before;
        vecs[0]  = '{r:1, p:0, q:0, c:0, nn:4'd0, exp_wr:0, exp_rd:0, exp_level:5'd0, exp_ready:0};
        vecs[1]  = '{r:0, p:1, q:0, c:0, nn:4'd1, exp_wr:1, exp_rd:0, exp_level:5'd1, exp_ready:1};
        vecs[2]  = '{r:0, p:1, q:0, c:0, nn:4'd1, exp_wr:1, exp_rd:0, exp_level:5'd2, exp_ready:1};
        vecs[3]  = '{r:0, p:0, q:1, c:0, nn:4'd0, exp_wr:0, exp_rd:1, exp_level:5'd1, exp_ready:0};
        vecs[4]  = '{r:0, p:1, q:1, c:0, nn:4'd0, exp_wr:1, exp_rd:1, exp_level:5'd1, exp_ready:0};
        vecs[5]  = '{r:0, p:0, q:1, c:0, nn:4'd0, exp_wr:0, exp_rd:1, exp_level:5'd0, exp_ready:0};
        vecs[6]  = '{r:0, p:0, q:1, c:0, nn:4'd0, exp_wr:0, exp_rd:0, exp_level:5'd0, exp_ready:0};
        vecs[7]  = '{r:0, p:1, q:1, c:0, nn:4'd2, exp_wr:1, exp_rd:0, exp_level:5'd1, exp_ready:0};
        vecs[8]  = '{r:0, p:1, q:0, c:0, nn:4'd2, exp_wr:1, exp_rd:0, exp_level:5'd2, exp_ready:0};
        vecs[9]  = '{r:0, p:1, q:0, c:0, nn:4'd2, exp_wr:1, exp_rd:0, exp_level:5'd3, exp_ready:0};
        vecs[10] = '{r:0, p:1, q:0, c:0, nn:4'd2, exp_wr:1, exp_rd:0, exp_level:5'd4, exp_ready:1};
        vecs[11] = '{r:0, p:0, q:1, c:0, nn:4'd0, exp_wr:0, exp_rd:1, exp_level:5'd3, exp_ready:0};

        modelReset();
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r, vecs[i].p, vecs[i].q, vecs[i].nn, vecs[i].c);
            checkOutput($sformatf("tbl%0d_wr", i), cap_wr, vecs[i].exp_wr);
            checkOutput($sformatf("tbl%0d_rd", i), cap_rd, vecs[i].exp_rd);
            checkOutput($sformatf("tbl%0d_level", i), level, vecs[i].exp_level);
            checkOutput($sformatf("tbl%0d_ready", i), ready, vecs[i].exp_ready);
        end

        // Fill to full, then push once more into the full FIFO.
        applyStimulus(1, 0, 0, 4'd0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'd0, 0);
        checkOutput("full_after_16", full, 1'b1);
        checkOutput("level_after_16", level, 5'd16);
        lvl_before = level;
        wa_before = wr_addr;
        applyStimulus(0, 1, 0, 4'd0, 0);
        checkOutput("push17_wr_en", cap_wr, 1'b0);
        checkOutput("push17_wr_addr", wr_addr, wa_before);
        checkOutput("push17_level", level, lvl_before);

        // Simultaneous push/pop while full, across the pointer wrap.
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 4'd0, 0);
        checkOutput("pp_full_level", level, 5'd16);

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 4'd0, 0);
        applyStimulus(0, 0, 1, 4'd0, 0);
        checkOutput("pop_empty_rd_en", cap_rd, 1'b0);
        applyStimulus(0, 0, 0, 4'd0, 1);
        checkOutput("underflow_cleared", underflow, 1'b0);
        applyStimulus(0, 1, 1, 4'd0, 0);
        checkOutput("pp_empty_level", level, 5'd1);
        applyStimulus(0, 0, 1, 4'd0, 0);

        // n=3 frame: ready after the ninth push, drops after the first pop.
        applyStimulus(1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 4'd3, 0);
        checkOutput("n3_ready", ready, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 4'd0, 0);
        checkOutput("n3_empty", empty, 1'b1);
        checkOutput("n3_ready_end", ready, 1'b0);

        // Reset in the middle of a frame, then an n=2 frame.
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 4'd3, 0);
        applyStimulus(1, 0, 0, 4'd3, 0);
        checkOutput("midrst_level", level, 5'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 4'd2, 0);
        checkOutput("n2_ready", ready, 1'b1);

        // n=0 pushes are stored but never make a frame.
        applyStimulus(1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'd0, 0);
        applyStimulus(0, 0, 0, 4'd0, 0);
        checkOutput("n0_level", level, 5'd3);
        checkOutput("n0_ready", ready, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
